// File: rtl/writeback_unit.sv
// Writeback arbiter: merges ALU results and load returns into one register-file
// write port, buffering colliding load returns and tracking outstanding loads.
module writeback_unit #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_is_load,
  output logic            issue_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            rf_en,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            overflow_err
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);

  logic [XLEN-1:0]  lq_data_q [LQ_DEPTH];
  logic [4:0]       lq_rd_q   [LQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      busy_q, busy_d;
  logic             rf_en_q, rf_en_d, rf_load_q, rf_load_d, ovf_q, ovf_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_data_q, rf_data_d;

  logic             lq_empty_s, lq_full_s, mem_acc_s, enq_s, deq_s, issue_acc_s;
  logic             sel_valid_s, sel_load_s;
  logic [4:0]       sel_rd_s;
  logic [XLEN-1:0]  sel_data_s;
  logic [31:0]      set_mask_s, clr_mask_s;

  assign lq_empty_s   = (cnt_q == {CNT_W{1'b0}});
  assign lq_full_s    = (cnt_q == DEPTH_C);
  assign mem_ready    = ~lq_full_s;
  assign mem_acc_s    = mem_valid & ~lq_full_s;
  assign issue_ready  = ~((issue_rd != 5'd0) & busy_q[issue_rd]);
  assign stall        = ((rs1 != 5'd0) & busy_q[rs1]) | ((rs2 != 5'd0) & busy_q[rs2]);
  assign issue_acc_s  = issue_valid & issue_ready & issue_is_load & (issue_rd != 5'd0);

  // Source priority: ALU, then buffered load, then same-cycle load bypass.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_load_s  = 1'b0;
    sel_rd_s    = 5'd0;
    sel_data_s  = {XLEN{1'b0}};
    enq_s       = 1'b0;
    deq_s       = 1'b0;
    if (alu_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = alu_rd;
      sel_data_s  = alu_data;
      enq_s       = mem_acc_s;
    end else if (!lq_empty_s) begin
      sel_valid_s = 1'b1;
      sel_load_s  = 1'b1;
      sel_rd_s    = lq_rd_q[head_q];
      sel_data_s  = lq_data_q[head_q];
      deq_s       = 1'b1;
      enq_s       = mem_acc_s;
    end else if (mem_acc_s) begin
      sel_valid_s = 1'b1;
      sel_load_s  = 1'b1;
      sel_rd_s    = mem_rd;
      sel_data_s  = mem_data;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Queue pointer/occupancy next state; pointers wrap naturally at a power-of-2 depth.
  always_comb begin
    head_d = deq_s ? head_q + PTR_W'(1) : head_q;
    tail_d = enq_s ? tail_q + PTR_W'(1) : tail_q;
    case ({enq_s, deq_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Scoreboard and write-port next state. A load clears its busy bit only once
  // its registered write is on the port; a same-edge set takes precedence.
  always_comb begin
    set_mask_s = issue_acc_s ? (32'd1 << issue_rd) : 32'd0;
    clr_mask_s = (rf_en_q & rf_load_q) ? (32'd1 << rf_rd_q) : 32'd0;
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    rf_en_d    = sel_valid_s & (sel_rd_s != 5'd0);
    rf_load_d  = sel_valid_s & sel_load_s;
    rf_rd_d    = sel_valid_s ? sel_rd_s : rf_rd_q;
    rf_data_d  = sel_valid_s ? sel_data_s : rf_data_q;
    ovf_d      = ovf_q | (mem_valid & lq_full_s);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q    <= {PTR_W{1'b0}};
      tail_q    <= {PTR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 32'd0;
      rf_en_q   <= 1'b0;
      rf_load_q <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= {XLEN{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      rf_en_q   <= rf_en_d;
      rf_load_q <= rf_load_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      ovf_q     <= ovf_d;
    end
  end

  // Queue payload storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      lq_data_q[tail_q] <= mem_data;
      lq_rd_q[tail_q]   <= mem_rd;
    end else begin
      lq_data_q[tail_q] <= lq_data_q[tail_q];
      lq_rd_q[tail_q]   <= lq_rd_q[tail_q];
    end
  end

  assign rf_en        = rf_en_q;
  assign rf_rd        = rf_rd_q;
  assign rf_data      = rf_data_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_writeback_unit;
  localparam int XLEN = 32;
  localparam int LQ_DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, issue_valid, issue_is_load, issue_ready, stall;
  logic [4:0] issue_rd, rs1, rs2, alu_rd, mem_rd, rf_rd;
  logic alu_valid, mem_valid, mem_ready, rf_en, overflow_err;
  logic [XLEN-1:0] alu_data, mem_data, rf_data;

  writeback_unit #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_load(issue_is_load),
    .issue_ready(issue_ready), .rs1(rs1), .rs2(rs2), .stall(stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data), .overflow_err(overflow_err)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t        lq_m[$];
  wr_t        exp_q[$];
  wr_t        mw;
  logic [31:0] busy_m;
  logic       ovf_m, pend_v;
  logic [4:0] pend_rd;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = 5'd0; issue_is_load = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
  endtask

  task automatic model_clear();
    lq_m.delete(); exp_q.delete();
    busy_m = 32'd0; ovf_m = 1'b0; pend_v = 1'b0; pend_rd = 5'd0;
  endtask

  // One clock cycle: inputs already driven at the negedge; check, model, advance.
  task automatic cycle();
    wr_t w;
    bit wv, wl, mready, acc, ir;
    #1;
    mready = (lq_m.size() < LQ_DEPTH);
    ir = !((issue_rd != 5'd0) && busy_m[issue_rd]);
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, mready});
    chk("stall", {31'd0, stall},
        {31'd0, ((rs1 != 5'd0) && busy_m[rs1]) || ((rs2 != 5'd0) && busy_m[rs2])});
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, ir});
    chk("overflow_err", {31'd0, overflow_err}, {31'd0, ovf_m});
    acc = mem_valid && mready;
    wv = 1'b0; wl = 1'b0; w = '0;
    if (alu_valid) begin
      w.rd = alu_rd; w.data = alu_data; wv = 1'b1;
    end else if (lq_m.size() > 0) begin
      w = lq_m.pop_front(); wv = 1'b1; wl = 1'b1;
    end else if (acc) begin
      w.rd = mem_rd; w.data = mem_data; wv = 1'b1; wl = 1'b1; acc = 1'b0;
    end
    if (acc) begin
      wr_t e;
      e.rd = mem_rd; e.data = mem_data;
      lq_m.push_back(e);
    end
    if (mem_valid && !mready) ovf_m = 1'b1;
    if (wv && w.rd != 5'd0) exp_q.push_back(w);
    if (pend_v) busy_m[pend_rd] = 1'b0;
    if (issue_valid && ir && issue_is_load && issue_rd != 5'd0) busy_m[issue_rd] = 1'b1;
    busy_m[0] = 1'b0;
    pend_v = wv && wl && (w.rd != 5'd0);
    pend_rd = w.rd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_rf_en", {31'd0, rf_en}, 32'd0);
    chk("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_overflow", {31'd0, overflow_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    model_clear();
    idle_inputs();
    repeat (2) @(negedge clk);
    #2;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: every register-file write must match the next expected write in order.
  always @(negedge clk) begin
    if (resetn === 1'b1 && rf_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rf_write: got rd=%0d data=0x%0h expected no write", rf_rd, rf_data);
      end else begin
        mw = exp_q.pop_front();
        chk("rf_rd", {27'd0, rf_rd}, {27'd0, mw.rd});
        chk("rf_data", rf_data, mw.data);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    do_reset();
    chk("post_rst_no_pulse", {31'd0, rf_en}, 32'd0);

    // ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
    cycle();
    idle_inputs();
    chk("alu_en", {31'd0, rf_en}, 32'd1);
    chk("alu_rd", {27'd0, rf_rd}, 32'd5);
    chk("alu_data", rf_data, 32'hAA);
    cycle();
    chk("alu_en_low", {31'd0, rf_en}, 32'd0);
    chk("alu_rd_hold", {27'd0, rf_rd}, 32'd5);
    chk("alu_data_hold", rf_data, 32'hAA);

    // Collision: ALU first, load next cycle
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
    cycle();
    idle_inputs();
    chk("col_rd3", {27'd0, rf_rd}, 32'd3);
    cycle();
    chk("col_en", {31'd0, rf_en}, 32'd1);
    chk("col_rd4", {27'd0, rf_rd}, 32'd4);
    chk("col_data", rf_data, 32'h22);
    chk("col_mem_ready", {31'd0, mem_ready}, 32'd1);

    // Scoreboard: load to x7 blocks readers and re-issue until its write lands
    issue_valid = 1'b1; issue_rd = 5'd7; issue_is_load = 1'b1;
    cycle();
    idle_inputs();
    rs1 = 5'd7; issue_rd = 5'd7;
    #1;
    chk("sb_stall", {31'd0, stall}, 32'd1);
    chk("sb_waw", {31'd0, issue_ready}, 32'd0);
    repeat (3) cycle();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
    cycle();
    mem_valid = 1'b0;
    #1;
    chk("sb_wr_en", {31'd0, rf_en}, 32'd1);
    chk("sb_stall_during_wr", {31'd0, stall}, 32'd1);
    chk("sb_waw_during_wr", {31'd0, issue_ready}, 32'd0);
    cycle();
    #1;
    chk("sb_stall_clear", {31'd0, stall}, 32'd0);
    chk("sb_issue_ok", {31'd0, issue_ready}, 32'd1);
    idle_inputs();

    // Overflow: ALU every cycle, three load returns into a two-entry queue
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'(i + 1);
      mem_valid = 1'b1; mem_rd = 5'(10 + i); mem_data = 32'(32'h100 + i);
      if (i == 2) begin
        #1;
        chk("ovf_mem_ready_low", {31'd0, mem_ready}, 32'd0);
      end
      cycle();
    end
    idle_inputs();
    #1;
    chk("ovf_flag", {31'd0, overflow_err}, 32'd1);
    repeat (3) cycle();

    // x0 discard: buffered load to x0 is consumed without a write
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF;
    cycle();
    idle_inputs();
    cycle();
    chk("x0_no_write", {31'd0, rf_en}, 32'd0);
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h5A;
    cycle();
    idle_inputs();
    chk("x0_queue_empty_bypass", {27'd0, rf_rd}, 32'd2);
    cycle();

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      alu_valid = ($urandom_range(0, 99) < 40);
      alu_rd = 5'($urandom_range(0, 15));
      alu_data = $urandom;
      mem_valid = ($urandom_range(0, 99) < 50);
      mem_rd = 5'($urandom_range(0, 15));
      mem_data = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_rd = 5'($urandom_range(0, 15));
      issue_is_load = ($urandom_range(0, 1) == 1);
      rs1 = 5'($urandom_range(0, 15));
      rs2 = 5'($urandom_range(0, 15));
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();

    // Reset mid-operation: full queue, busy x9, overflow set
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd9; issue_is_load = 1'b1;
    cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = 32'(32'hC0 + i);
      mem_valid = 1'b1; mem_rd = 5'(12 + i); mem_data = 32'(32'hD0 + i);
      cycle();
    end
    idle_inputs();
    rs1 = 5'd9;
    #1;
    chk("mid_pre_full", {31'd0, mem_ready}, 32'd0);
    chk("mid_pre_stall", {31'd0, stall}, 32'd1);
    chk("mid_pre_ovf", {31'd0, overflow_err}, 32'd1);
    rs1 = 5'd9;
    do_reset();
    chk("mid_no_pulse0", {31'd0, rf_en}, 32'd0);
    cycle();
    chk("mid_no_pulse1", {31'd0, rf_en}, 32'd0);
    repeat (2) cycle();

    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
